// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - cell codes, referee states, line table and address helpers for the board store
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int BOARD_W   = 18;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    DRAW = 2'd2
  } ttt_state_t;

  // Line indices, matching the bit positions of gameover[7:0]
  localparam logic [2:0] LINE_ROW0 = 3'd0;
  localparam logic [2:0] LINE_ROW1 = 3'd1;
  localparam logic [2:0] LINE_ROW2 = 3'd2;
  localparam logic [2:0] LINE_COL0 = 3'd3;
  localparam logic [2:0] LINE_COL1 = 3'd4;
  localparam logic [2:0] LINE_COL2 = 3'd5;
  localparam logic [2:0] LINE_DIAG = 3'd6;
  localparam logic [2:0] LINE_ANTI = 3'd7;

  // Line-to-cell table: returns the three cell indices {c2, c1, c0} of a line
  function automatic logic [11:0] line_cells(input logic [2:0] line);
    case (line)
      LINE_ROW0: return {4'd2, 4'd1, 4'd0};
      LINE_ROW1: return {4'd5, 4'd4, 4'd3};
      LINE_ROW2: return {4'd8, 4'd7, 4'd6};
      LINE_COL0: return {4'd6, 4'd3, 4'd0};
      LINE_COL1: return {4'd7, 4'd4, 4'd1};
      LINE_COL2: return {4'd8, 4'd5, 4'd2};
      LINE_DIAG: return {4'd8, 4'd4, 4'd0};
      LINE_ANTI: return {4'd6, 4'd4, 4'd2};
      default:   return 12'd0;
    endcase
  endfunction

  // Row 3 or column 3 does not exist on the board
  function automatic logic addr_valid(input logic [3:0] a);
    return (a[3:2] != 2'd3) && (a[1:0] != 2'd3);
  endfunction

  function automatic logic [3:0] cell_index(input logic [3:0] a);
    return ({2'b00, a[3:2]} * 4'd3) + {2'b00, a[1:0]};
  endfunction

  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] board, input logic [3:0] idx);
    return board[{idx, 1'b0} +: 2];
  endfunction

  // Read through a cursor-style address; off-board addresses read as empty
  function automatic logic [1:0] read_cell(input logic [BOARD_W-1:0] board, input logic [3:0] a);
    return addr_valid(a) ? cell_at(board, cell_index(a)) : CELL_EMPTY;
  endfunction

endpackage

// File: rtl/ttt_line_detect.sv
// rtl/ttt_line_detect.sv - combinational three-in-a-row detector over the 18-bit board
module ttt_line_detect
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  output logic [7:0]         lines,
  output logic [1:0]         owner
);

  logic [11:0] cs;
  logic [1:0]  ca;
  logic [1:0]  cb;
  logic [1:0]  cc;

  // Flag every line whose three cells hold the same non-empty mark; owner is that mark
  always_comb begin
    lines = '0;
    owner = CELL_EMPTY;
    cs    = '0;
    ca    = CELL_EMPTY;
    cb    = CELL_EMPTY;
    cc    = CELL_EMPTY;
    for (int l = 0; l < NUM_LINES; l++) begin
      cs = line_cells(3'(l));
      ca = cell_at(board, cs[3:0]);
      cb = cell_at(board, cs[7:4]);
      cc = cell_at(board, cs[11:8]);
      if ((ca != CELL_EMPTY) && (ca == cb) && (cb == cc)) begin
        lines[l] = 1'b1;
        owner    = ca;
      end
    end
  end

endmodule

// File: rtl/board_reg_array.sv
// rtl/board_reg_array.sv - tic-tac-toe board store and referee; TTT_SCORE_EN adds win counters
module board_reg_array
  import ttt_pkg::*;
#(
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         addr,
  input  logic [1:0]         wd,
  input  logic               wen,
  output logic [1:0]         ud,
  output logic [9:0]         gameover,
  input  logic [3:0]         disp_addr,
  output logic [1:0]         disp_data,
  output logic [3:0]         move_cnt
`ifdef TTT_SCORE_EN
  ,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2
`endif
);

  if (SCORE_W < 1) begin : g_bad_score_w
    $error("SCORE_W must be at least 1");
  end

  ttt_state_t         state;
  ttt_state_t         state_next;
  logic [BOARD_W-1:0] board;
  logic [3:0]         move_cnt_q;
  logic [7:0]         lines_q;
  logic               winner_p1_q;
  logic               check_q;
  logic [7:0]         lines_now;
  logic [1:0]         owner_now;
  logic               game_ends;
  logic               wr_accept;
  logic               restart;

  ttt_line_detect u_line_detect (
    .board (board),
    .lines (lines_now),
    .owner (owner_now)
  );

  // A write waiting to be judged that ends the game must not let another mark in
  assign game_ends = check_q && ((|lines_now) || (move_cnt_q == 4'd9));
  assign wr_accept = (state == PLAY) && wen && addr_valid(addr) &&
                     (read_cell(board, addr) == CELL_EMPTY) &&
                     ((wd == CELL_P1) || (wd == CELL_P2)) && !game_ends;
  assign restart   = (state != PLAY) && wen;

  assign ud        = read_cell(board, addr);
  assign disp_data = read_cell(board, disp_addr);
  assign move_cnt  = move_cnt_q;
  assign gameover  = {(state != PLAY), winner_p1_q, lines_q};

  // Referee state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PLAY;
    end else begin
      state <= state_next;
    end
  end

  // Judge the board the cycle after a mark lands; any pulse after the game ends starts a new one
  always_comb begin
    state_next = state;
    case (state)
      PLAY: begin
        if (check_q) begin
          if (|lines_now) begin
            state_next = WON;
          end else if (move_cnt_q == 4'd9) begin
            state_next = DRAW;
          end
        end
      end
      WON, DRAW: begin
        if (wen) begin
          state_next = PLAY;
        end
      end
      default: state_next = PLAY;
    endcase
  end

  // Board cells, move count and latched line status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board       <= '0;
      move_cnt_q  <= '0;
      lines_q     <= '0;
      winner_p1_q <= 1'b0;
      check_q     <= 1'b0;
    end else if (restart) begin
      board       <= '0;
      move_cnt_q  <= '0;
      lines_q     <= '0;
      winner_p1_q <= 1'b0;
      check_q     <= 1'b0;
    end else begin
      check_q <= wr_accept;
      if (wr_accept) begin
        board[{cell_index(addr), 1'b0} +: 2] <= wd;
        move_cnt_q <= move_cnt_q + 4'd1;
      end
      if (check_q && (state == PLAY) && (|lines_now)) begin
        lines_q     <= lines_now;
        winner_p1_q <= (owner_now == CELL_P1);
      end
    end
  end

`ifdef TTT_SCORE_EN
  logic [SCORE_W-1:0] score_p1_q;
  logic [SCORE_W-1:0] score_p2_q;

  assign score_p1 = score_p1_q;
  assign score_p2 = score_p2_q;

  // Saturating win tallies, kept across games and cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_p1_q <= '0;
      score_p2_q <= '0;
    end else if ((state == PLAY) && (state_next == WON)) begin
      if (owner_now == CELL_P1) begin
        if (score_p1_q != '1) begin
          score_p1_q <= score_p1_q + 1'b1;
        end
      end else begin
        if (score_p2_q != '1) begin
          score_p2_q <= score_p2_q + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_board_reg_array.sv
// tb/tb_board_reg_array.sv - self-checking bench for board_reg_array with a game-level reference model
module tb_board_reg_array;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    addr;
  logic [1:0]    wd;
  logic          wen;
  logic [1:0]    ud;
  logic [9:0]    gameover;
  logic [3:0]    disp_addr;
  logic [1:0]    disp_data;
  logic [3:0]    move_cnt;
`ifdef TTT_SCORE_EN
  logic [SW-1:0] score_p1;
  logic [SW-1:0] score_p2;
`endif

  int errors = 0;
  int checks = 0;

  board_reg_array #(.SCORE_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wd        (wd),
    .wen       (wen),
    .ud        (ud),
    .gameover  (gameover),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .move_cnt  (move_cnt)
`ifdef TTT_SCORE_EN
    ,
    .score_p1  (score_p1),
    .score_p2  (score_p2)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the game as the rules describe it
  int m_cell [9];
  int m_cnt     = 0;
  int m_over    = 0;
  int m_p1      = 0;
  int m_lines   = 0;
  int m_pending = 0;
  int m_s1      = 0;
  int m_s2      = 0;
  int lines3 [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic int m_read(input logic [3:0] a);
    int row = int'(a[3:2]);
    int col = int'(a[1:0]);
    if (row > 2 || col > 2) return 0;
    return m_cell[row * 3 + col];
  endfunction

  function automatic logic [3:0] caddr(input int c);
    return 4'(((c / 3) << 2) | (c % 3));
  endfunction

  task automatic model_clear_game();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_cnt = 0; m_over = 0; m_p1 = 0; m_lines = 0; m_pending = 0;
  endtask

  task automatic model_step();
    int mask;
    int own;
    int row;
    int col;
    if (!rst_n) begin
      model_clear_game();
      m_s1 = 0;
      m_s2 = 0;
      return;
    end
    if (m_pending != 0) begin
      m_pending = 0;
      mask = 0;
      own  = 0;
      for (int l = 0; l < 8; l++) begin
        if (m_cell[lines3[l][0]] != 0 && m_cell[lines3[l][0]] == m_cell[lines3[l][1]] &&
            m_cell[lines3[l][1]] == m_cell[lines3[l][2]]) begin
          mask = mask | (1 << l);
          own  = m_cell[lines3[l][0]];
        end
      end
      if (mask != 0) begin
        m_over  = 1;
        m_lines = mask;
        m_p1    = (own == 1) ? 1 : 0;
        if (own == 1) m_s1 = (m_s1 < (1 << SW) - 1) ? m_s1 + 1 : m_s1;
        else          m_s2 = (m_s2 < (1 << SW) - 1) ? m_s2 + 1 : m_s2;
      end else if (m_cnt == 9) begin
        m_over = 1;
      end
    end
    if (wen) begin
      if (m_over != 0) begin
        model_clear_game();
      end else begin
        row = int'(addr[3:2]);
        col = int'(addr[1:0]);
        if (row < 3 && col < 3 && m_cell[row * 3 + col] == 0 && (wd == 2'b01 || wd == 2'b10)) begin
          m_cell[row * 3 + col] = int'(wd);
          m_cnt     = m_cnt + 1;
          m_pending = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Every cycle, compare the DUT against the model away from the clock edge
  initial begin
    forever begin
      @(negedge clk);
      chk("ud", int'(ud), m_read(addr));
      chk("disp_data", int'(disp_data), m_read(disp_addr));
      chk("move_cnt", int'(move_cnt), m_cnt);
      chk("gameover", int'(gameover), (m_over << 9) | (m_p1 << 8) | m_lines);
`ifdef TTT_SCORE_EN
      chk("score_p1", int'(score_p1), m_s1);
      chk("score_p2", int'(score_p2), m_s2);
`endif
    end
  end

  task automatic pulse(input logic [3:0] a, input logic [1:0] d);
    @(posedge clk);
    #1;
    addr = a;
    wd   = d;
    wen  = 1'b1;
    @(posedge clk);
    #1;
    wen  = 1'b0;
  endtask

  // Alternating P1/P2 moves by cell index, P1 first, with idle cycles between pulses
  task automatic play(input int seq[9], input int n);
    for (int i = 0; i < n; i++) begin
      pulse(caddr(seq[i]), (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i != n - 1) repeat (2) @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g_win[9]  = '{0, 4, 1, 5, 2, 0, 0, 0, 0};
    int g_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int g_p2[9]   = '{0, 1, 3, 4, 8, 7, 0, 0, 0};
    int g_ninth[9] = '{0, 3, 1, 4, 5, 7, 6, 8, 2};

    rst_n = 1'b0; addr = 4'h0; wd = 2'b00; wen = 1'b0; disp_addr = 4'h0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset gameover", int'(gameover), 0);
    chk("reset move_cnt", int'(move_cnt), 0);
    chk("reset ud", int'(ud), 0);

    pulse(4'h5, 2'b01);
    chk("first write ud", int'(ud), 1);
    chk("first write move_cnt", int'(move_cnt), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("first write gameover", int'(gameover), 0);

    pulse(4'h5, 2'b10);
    chk("occupied write ud", int'(ud), 1);
    chk("occupied write move_cnt", int'(move_cnt), 1);
    pulse(4'h3, 2'b01);
    chk("col3 write move_cnt", int'(move_cnt), 1);
    chk("col3 read ud", int'(ud), 0);
    pulse(4'h0, 2'b11);
    chk("bad code move_cnt", int'(move_cnt), 1);
    disp_addr = 4'h5;
    #1 chk("disp read", int'(disp_data), 1);
    disp_addr = 4'hF;
    #1 chk("disp invalid", int'(disp_data), 0);

    // Asynchronous reset between clock edges
    addr = 4'h5;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async move_cnt", int'(move_cnt), 0);
    chk("async gameover", int'(gameover), 0);
    chk("async ud", int'(ud), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    play(g_win, 5);
    chk("p1 row0 win", int'(gameover), 10'h301);
    pulse(caddr(6), 2'b10);
    chk("restart move_cnt", int'(move_cnt), 0);
    chk("restart ud", int'(ud), 0);
    chk("restart gameover", int'(gameover), 0);
`ifdef TTT_SCORE_EN
    chk("score kept", int'(score_p1), 1);
`endif
    repeat (2) @(posedge clk);

    play(g_draw, 9);
    chk("draw gameover", int'(gameover), 10'h200);
    chk("draw move_cnt", int'(move_cnt), 9);
    pulse(4'h0, 2'b01);
    repeat (2) @(posedge clk);

    play(g_p2, 6);
    chk("p2 col1 win", int'(gameover), 10'h210);
    pulse(4'h0, 2'b01);
    repeat (2) @(posedge clk);

    play(g_ninth, 9);
    chk("ninth move win", int'(gameover), 10'h301);
    chk("ninth move_cnt", int'(move_cnt), 9);
    pulse(4'h0, 2'b01);
    repeat (3) @(posedge clk);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
